// File: rtl/gray_conv_rr_arb.sv
// -----------------------------------------------------------------------------
// gray_conv_rr_arb
//
// Round-robin arbiter and sequencer that lets NREQ clients share one pipelined
// binary-to-Gray converter. Each cycle it grants at most one requester. It
// issues that requester's data to the converter and carries the requester ID
// through a LAT-deep tag pipeline. The ID and the converter's Gray result come
// back out as a registered, tagged response.
//
// Ports:
//   i_clk        clock
//   i_rst_n      synchronous active-low reset
//   i_en         global issue enable (0 = no new grants)
//   i_req        per-requester request level, held until granted
//   i_data       flattened request data, requester k at [k*(MSB+1) +: MSB+1]
//   o_gnt        registered one-hot grant pulse
//   o_conv_en    converter enable
//   o_conv_data  converter binary input
//   i_conv_vld   converter valid output
//   i_conv_gray  converter Gray output
//   o_rsp_vld    response valid pulse
//   o_rsp_id     requester ID of the response
//   o_rsp_gray   Gray result of the response
//   o_err        sticky protocol error (converter valid vs. tag disagreement)
// -----------------------------------------------------------------------------
module gray_conv_rr_arb #(
    parameter int NREQ = 4,
    parameter int MSB  = 3,
    parameter int LAT  = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_en,
    input  logic [NREQ-1:0]         i_req,
    input  logic [NREQ*(MSB+1)-1:0] i_data,
    output logic [NREQ-1:0]         o_gnt,
    output logic                    o_conv_en,
    output logic [MSB:0]            o_conv_data,
    input  logic                    i_conv_vld,
    input  logic [MSB:0]            i_conv_gray,
    output logic                    o_rsp_vld,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] o_rsp_id,
    output logic [MSB:0]            o_rsp_gray,
    output logic                    o_err
);

    localparam int W   = MSB + 1;
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Arbiter state
    logic [NREQ-1:0] gnt_q,       gnt_d;
    logic            conv_en_q,   conv_en_d;
    logic [W-1:0]    conv_data_q, conv_data_d;
    logic [IDW-1:0]  ptr_q,       ptr_d;
    logic [IDW-1:0]  gnt_id_q,    gnt_id_d;

    // Tag pipeline: stage 0 is loaded one cycle after issue, so stage LAT-1
    // lines up with the cycle the converter raises i_conv_vld.
    logic [LAT-1:0]          tag_vld_q;
    logic [LAT-1:0][IDW-1:0] tag_id_q;

    // Response / error state
    logic           rsp_vld_q,  rsp_vld_d;
    logic [IDW-1:0] rsp_id_q,   rsp_id_d;
    logic [W-1:0]   rsp_gray_q, rsp_gray_d;
    logic           err_q,      err_d;

    // Arbitration combinational signals
    logic [NREQ-1:0] elig;
    logic            win_found;
    logic [IDW-1:0]  win_id;
    logic            issue;
    logic            tag_out_vld;
    logic [IDW-1:0]  tag_out_id;

    assign tag_out_vld = tag_vld_q[LAT-1];
    assign tag_out_id  = tag_id_q[LAT-1];

    // Rotating first-match search starting at the priority pointer. A requester
    // granted last cycle is masked so its stale, not-yet-updated data is never
    // issued twice.
    always_comb begin
        int idx;
        // NOTE: every combinational output gets a default before any branch;
        // a path that leaves one unassigned would infer a latch.
        elig      = i_req & ~gnt_q;
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!win_found && elig[idx]) begin
                win_found = 1'b1;
                win_id    = IDW'(idx);
            end
        end
    end

    assign issue = i_en && win_found;

    // Next-state for arbiter, response and error registers
    always_comb begin
        gnt_d       = '0;
        conv_en_d   = issue;
        conv_data_d = conv_data_q;
        ptr_d       = ptr_q;
        gnt_id_d    = gnt_id_q;
        if (issue) begin
            gnt_d[win_id] = 1'b1;
            conv_data_d   = i_data[int'(win_id)*W +: W];
            gnt_id_d      = win_id;
            ptr_d         = (int'(win_id) == NREQ - 1) ? '0 : win_id + 1'b1;
        end

        // Only a valid converter result that matches an in-flight tag is
        // forwarded; a spurious valid is dropped and only flags the error.
        rsp_vld_d  = i_conv_vld && tag_out_vld;
        rsp_id_d   = rsp_id_q;
        rsp_gray_d = rsp_gray_q;
        if (rsp_vld_d) begin
            rsp_id_d   = tag_out_id;
            rsp_gray_d = i_conv_gray;
        end

        err_d = err_q || (i_conv_vld != tag_out_vld);
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!i_rst_n) begin
            gnt_q       <= '0;
            conv_en_q   <= 1'b0;
            conv_data_q <= '0;
            ptr_q       <= '0;
            gnt_id_q    <= '0;
            // NOTE: the tag pipeline is reset, not just its valid bits being
            // ignored, so a reset mid-operation discards every in-flight tag.
            tag_vld_q   <= '0;
            tag_id_q    <= '0;
            rsp_vld_q   <= 1'b0;
            rsp_id_q    <= '0;
            rsp_gray_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            gnt_q       <= gnt_d;
            conv_en_q   <= conv_en_d;
            conv_data_q <= conv_data_d;
            ptr_q       <= ptr_d;
            gnt_id_q    <= gnt_id_d;
            tag_vld_q[0] <= conv_en_q;
            tag_id_q[0]  <= gnt_id_q;
            for (int k = 1; k < LAT; k++) begin
                tag_vld_q[k] <= tag_vld_q[k-1];
                tag_id_q[k]  <= tag_id_q[k-1];
            end
            rsp_vld_q   <= rsp_vld_d;
            rsp_id_q    <= rsp_id_d;
            rsp_gray_q  <= rsp_gray_d;
            err_q       <= err_d;
        end
    end

    assign o_gnt       = gnt_q;
    assign o_conv_en   = conv_en_q;
    assign o_conv_data = conv_data_q;
    assign o_rsp_vld   = rsp_vld_q;
    assign o_rsp_id    = rsp_id_q;
    assign o_rsp_gray  = rsp_gray_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_gray_conv_rr_arb.sv
// -----------------------------------------------------------------------------
// tb_gray_conv_rr_arb
//
// Directed bench for gray_conv_rr_arb (NREQ=4, MSB=3, LAT=1). A behavioural
// one-cycle binary-to-Gray converter closes the loop. A vector table covers
// reset, round-robin rotation, the single-requester cadence and i_en gaps.
// Hand-written sequences cover the spurious-valid error and reset with a
// request in flight.
// -----------------------------------------------------------------------------
module tb_gray_conv_rr_arb;

    localparam int NREQ = 4;
    localparam int MSB  = 3;
    localparam int LAT  = 1;

    // Requester data: d3=7, d2=B, d1=2, d0=1 -> Gray 4, E, 3, 1
    localparam logic [15:0] DATA = 16'h7B21;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  req = '0;
    logic [15:0] data = '0;
    logic [3:0]  gnt;
    logic        conv_en;
    logic [3:0]  conv_data;
    logic        conv_vld;
    logic [3:0]  conv_gray;
    logic        rsp_vld;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_gray;
    logic        err;

    logic        force_vld = 1'b0;
    logic        model_vld;
    logic [3:0]  model_gray;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Shared converter model, reset together with the DUT
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            model_vld  <= 1'b0;
            model_gray <= '0;
        end else begin
            model_vld  <= conv_en;
            model_gray <= conv_data ^ (conv_data >> 1);
        end
    end

    assign conv_vld  = model_vld | force_vld;
    assign conv_gray = model_gray;

    gray_conv_rr_arb #(.NREQ(NREQ), .MSB(MSB), .LAT(LAT)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_en        (en),
        .i_req       (req),
        .i_data      (data),
        .o_gnt       (gnt),
        .o_conv_en   (conv_en),
        .o_conv_data (conv_data),
        .i_conv_vld  (conv_vld),
        .i_conv_gray (conv_gray),
        .o_rsp_vld   (rsp_vld),
        .o_rsp_id    (rsp_id),
        .o_rsp_gray  (rsp_gray),
        .o_err       (err)
    );

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [3:0] cd;
        logic       rv;
        logic [1:0] rid;
        logic [3:0] rg;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic e, logic [3:0] q, logic [3:0] g,
                                logic [3:0] cd, logic rv, logic [1:0] rid,
                                logic [3:0] rg);
        vec_t v;
        v.rst_n = r; v.en = e; v.req = q; v.gnt = g;
        v.cd = cd; v.rv = rv; v.rid = rid; v.rg = rg;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs are changed 1 time unit after an edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Expected values are the outputs after the edge that samples the row's inputs.
        //                 rst en  req    gnt    cd    rv  rid rg
        // Reset with all requesting, then full rotation 0,1,2,3,0
        vecs.push_back(mk(0, 1, 4'hF, 4'b0000, 4'h0, 0, 0, 4'h0));
        vecs.push_back(mk(0, 1, 4'hF, 4'b0000, 4'h0, 0, 0, 4'h0));
        vecs.push_back(mk(1, 1, 4'hF, 4'b0001, 4'h1, 0, 0, 4'h0));
        vecs.push_back(mk(1, 1, 4'hF, 4'b0010, 4'h2, 0, 0, 4'h0));
        vecs.push_back(mk(1, 1, 4'hF, 4'b0100, 4'hB, 1, 0, 4'h1));
        vecs.push_back(mk(1, 1, 4'hF, 4'b1000, 4'h7, 1, 1, 4'h3));
        vecs.push_back(mk(1, 1, 4'hF, 4'b0001, 4'h1, 1, 2, 4'hE));
        vecs.push_back(mk(1, 1, 4'h0, 4'b0000, 4'h1, 1, 3, 4'h4));
        vecs.push_back(mk(1, 1, 4'h0, 4'b0000, 4'h1, 1, 0, 4'h1));
        vecs.push_back(mk(1, 1, 4'h0, 4'b0000, 4'h1, 0, 0, 4'h1));
        // Single continuous requester 2: issued every other cycle
        vecs.push_back(mk(1, 1, 4'h4, 4'b0100, 4'hB, 0, 0, 4'h1));
        vecs.push_back(mk(1, 1, 4'h4, 4'b0000, 4'hB, 0, 0, 4'h1));
        vecs.push_back(mk(1, 1, 4'h4, 4'b0100, 4'hB, 1, 2, 4'hE));
        vecs.push_back(mk(1, 1, 4'h4, 4'b0000, 4'hB, 0, 2, 4'hE));
        vecs.push_back(mk(1, 1, 4'h0, 4'b0000, 4'hB, 1, 2, 4'hE));
        vecs.push_back(mk(1, 1, 4'h0, 4'b0000, 4'hB, 0, 2, 4'hE));
        // Requesters 1 and 3 with i_en dropped for 3 cycles (pointer at 3)
        vecs.push_back(mk(1, 1, 4'hA, 4'b1000, 4'h7, 0, 2, 4'hE));
        vecs.push_back(mk(1, 1, 4'hA, 4'b0010, 4'h2, 0, 2, 4'hE));
        vecs.push_back(mk(1, 0, 4'hA, 4'b0000, 4'h2, 1, 3, 4'h4));
        vecs.push_back(mk(1, 0, 4'hA, 4'b0000, 4'h2, 1, 1, 4'h3));
        vecs.push_back(mk(1, 0, 4'hA, 4'b0000, 4'h2, 0, 1, 4'h3));
        vecs.push_back(mk(1, 1, 4'hA, 4'b1000, 4'h7, 0, 1, 4'h3));
        vecs.push_back(mk(1, 1, 4'hA, 4'b0010, 4'h2, 0, 1, 4'h3));
        vecs.push_back(mk(1, 1, 4'h0, 4'b0000, 4'h2, 1, 3, 4'h4));
        vecs.push_back(mk(1, 1, 4'h0, 4'b0000, 4'h2, 1, 1, 4'h3));
        vecs.push_back(mk(1, 1, 4'h0, 4'b0000, 4'h2, 0, 1, 4'h3));

        data = DATA;
        for (int i = 0; i < vecs.size(); i++) begin
            rst_n = vecs[i].rst_n;
            en    = vecs[i].en;
            req   = vecs[i].req;
            step();
            check($sformatf("row%0d gnt", i),       32'(gnt),       32'(vecs[i].gnt));
            check($sformatf("row%0d conv_en", i),   32'(conv_en),   32'(|vecs[i].gnt));
            check($sformatf("row%0d conv_data", i), 32'(conv_data), 32'(vecs[i].cd));
            check($sformatf("row%0d rsp_vld", i),   32'(rsp_vld),   32'(vecs[i].rv));
            check($sformatf("row%0d rsp_id", i),    32'(rsp_id),    32'(vecs[i].rid));
            check($sformatf("row%0d rsp_gray", i),  32'(rsp_gray),  32'(vecs[i].rg));
            check($sformatf("row%0d err", i),       32'(err),       32'h0);
        end

        // Spurious converter valid with nothing in flight
        req = '0;
        force_vld = 1'b1;
        step();
        force_vld = 1'b0;
        check("spurious err set", 32'(err), 32'h1);
        check("spurious rsp dropped", 32'(rsp_vld), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("err sticky %0d", i), 32'(err), 32'h1);
            check($sformatf("no rsp after spurious %0d", i), 32'(rsp_vld), 32'h0);
        end
        rst_n = 1'b0;
        step();
        check("err cleared by reset", 32'(err), 32'h0);

        // Reset one cycle after a grant discards the in-flight request
        rst_n = 1'b1;
        req   = 4'h4;
        step();
        check("pre-reset grant", 32'(gnt), 32'h4);
        check("pre-reset conv_data", 32'(conv_data), 32'hB);
        rst_n = 1'b0;
        req   = 4'h0;
        step();
        check("reset gnt", 32'(gnt), 32'h0);
        check("reset conv_en", 32'(conv_en), 32'h0);
        check("reset rsp_vld", 32'(rsp_vld), 32'h0);
        rst_n = 1'b1;
        req   = 4'hF;
        step();
        check("post-reset grant from ptr 0", 32'(gnt), 32'h1);
        check("discarded rsp", 32'(rsp_vld), 32'h0);
        check("post-reset err", 32'(err), 32'h0);
        req = 4'h0;
        step();
        check("post-reset idle rsp", 32'(rsp_vld), 32'h0);
        step();
        check("post-reset rsp_vld", 32'(rsp_vld), 32'h1);
        check("post-reset rsp_id", 32'(rsp_id), 32'h0);
        check("post-reset rsp_gray", 32'(rsp_gray), 32'h1);
        step();
        check("post-reset rsp pulse", 32'(rsp_vld), 32'h0);
        check("final err", 32'(err), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
